esfa_vector_loader: RTL and testbench

- Writer side of the ESFA test-vector memory. It receives a byte stream of 64-bit ESFA instruction words, packs them, checks their sequence, and writes them into the vector block RAM at the 8-byte address stride the ESFA runner reads with.
- Sits between the host/UART byte source and the write port of the vector BRAM. After loading, the runner can execute the program without regenerating the memory image.

---
 rtl/esfa_pkg.sv | 37 +++
 rtl/esfa_byte_packer.sv | 40 ++++
 rtl/esfa_vector_loader.sv | 132 +++++++++++++
 tb/tb_esfa_vector_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esfa_pkg.sv
// ============================================================================
// Module   : esfa_pkg
// Brief    : Shared ESFA word layout, loader state encoding and error codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package esfa_pkg;

    localparam int ISMUT_BIT   = 0;
    localparam int EXPBOOL_BIT = 1;
    localparam int EOP_BIT     = 2;
    localparam int HANDLE_LSB  = 8;
    localparam int INDEX_LSB   = 16;
    localparam int VALUE_LSB   = 24;
    localparam int SEL_LSB     = 32;
    localparam int EXPVAL_LSB  = 40;
    localparam int ID_LSB      = 48;
    localparam int FIELD_W     = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SEQ   = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    // Stream byte index at which the instruction ID arrives.
    localparam logic [2:0] ID_BYTE_IDX = 3'(ID_LSB / FIELD_W);

endpackage

`default_nettype wire

// File: rtl/esfa_byte_packer.sv
// ============================================================================
// Module   : esfa_byte_packer
// Brief    : Little-endian packer assembling eight stream bytes into a word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module esfa_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [2:0]  idx_o,
    output logic [63:0] word_o
);

    logic [2:0]  idx_q;
    logic [63:0] word_q;

    // The 3-bit index wraps from 7 to 0 by itself after the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 3'd0;
            word_q <= 64'd0;
        end else if (clear_i) begin
            idx_q  <= 3'd0;
            word_q <= 64'd0;
        end else if (load_i) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_i;
            idx_q                        <= idx_q + 3'd1;
        end
    end

    assign idx_o  = idx_q;
    assign word_o = word_q;

endmodule

`default_nettype wire

// File: rtl/esfa_vector_loader.sv
// ============================================================================
// Module   : esfa_vector_loader
// Brief    : Packs a byte stream into ESFA words and writes them to vector BRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module esfa_vector_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_STRIDE = 8,
    parameter int unsigned MAX_WORDS   = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [15:0] words_written
);

    import esfa_pkg::*;

    logic [2:0]  state_q, state_d;
    logic [15:0] ww_q, ww_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  code_q, code_d;

    logic        w_clear;
    logic        w_load;
    logic        w_id_bad;
    logic [2:0]  w_idx;
    logic [63:0] w_word;

    // A byte is never packed in the cycle an abort discards the session.
    assign w_load   = (state_q == ST_COLLECT) && s_valid && !abort;
    assign w_id_bad = (w_idx == ID_BYTE_IDX) && (s_data != ww_q[7:0]);

    esfa_byte_packer u_packer (
        .clk     (clk),
        .rst     (reset),
        .clear_i (w_clear),
        .load_i  (w_load),
        .byte_i  (s_data),
        .idx_o   (w_idx),
        .word_o  (w_word)
    );

    always_comb begin
        state_d = state_q;
        ww_d    = ww_q;
        addr_d  = addr_q;
        code_d  = code_q;
        w_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    ww_d    = 16'd0;
                    addr_d  = BASE_ADDR;
                    code_d  = ERR_NONE;
                    w_clear = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_d = ST_ERR;
                    code_d  = ERR_ABORT;
                end else if (s_valid) begin
                    if (w_id_bad) begin
                        state_d = ST_ERR;
                        code_d  = ERR_SEQ;
                    end else if (w_idx == 3'd7) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                ww_d   = ww_q + 16'd1;
                addr_d = addr_q + ADDR_STRIDE;
                if (abort) begin
                    state_d = ST_ERR;
                    code_d  = ERR_ABORT;
                end else if (w_word[EOP_BIT]) begin
                    state_d = ST_DONE;
                end else if ((32'(ww_q) + 32'd1) == MAX_WORDS) begin
                    state_d = ST_ERR;
                    code_d  = ERR_OVF;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ww_q    <= 16'd0;
            addr_q  <= BASE_ADDR;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            ww_q    <= ww_d;
            addr_q  <= addr_d;
            code_q  <= code_d;
        end
    end

    // addr_q tracks BASE_ADDR + ADDR_STRIDE * words_written at all times.
    assign s_ready       = (state_q == ST_COLLECT);
    assign mem_we        = (state_q == ST_WRITE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = w_word;
    assign busy          = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    assign done          = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERR);
    assign error_code    = code_q;
    assign words_written = ww_q;

endmodule

`default_nettype wire

// File: tb/tb_esfa_vector_loader.sv
// ============================================================================
// Module   : tb_esfa_vector_loader
// Brief    : Self-checking bench for esfa_vector_loader against a session model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_esfa_vector_loader;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready, mem_we, busy, done, error;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [1:0]  error_code;
    logic [15:0] words_written;

    esfa_vector_loader #(.BASE_ADDR(32'h0), .ADDR_STRIDE(8), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .error_code(error_code),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0, cyc = 0;

    // Session-level reference: a session is active or not, collects bytes into
    // a queue, and owes one memory write once eight bytes are in hand.
    bit          m_act = 0, m_wr = 0, m_done = 0, m_err = 0;
    logic [1:0]  m_code = 0;
    int          m_ww = 0;
    logic [7:0]  m_q[$];
    logic [63:0] m_word = 0;

    typedef struct { logic [31:0] a; logic [63:0] d; int c; } wr_t;
    wr_t wlog[$];

    typedef struct {
        logic [63:0] w; int nb;
        bit exp_we; bit exp_done; bit exp_err; logic [1:0] exp_code;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    function automatic void m_fail(input logic [1:0] c);
        m_act = 0; m_wr = 0; m_err = 1; m_code = c; m_q.delete();
    endfunction

    function automatic void model_step();
        if (reset) begin
            m_act = 0; m_wr = 0; m_done = 0; m_err = 0; m_code = 0; m_ww = 0; m_q.delete();
        end else if (m_wr) begin
            m_wr = 0; m_ww++;
            if (abort) m_fail(2'd3);
            else if (m_word[2]) begin m_act = 0; m_done = 1; end
            else if (m_ww == MAXW) m_fail(2'd2);
        end else if (m_act) begin
            if (abort) m_fail(2'd3);
            else if (s_valid) begin
                if (m_q.size() == 6 && s_data != 8'(m_ww)) m_fail(2'd1);
                else begin
                    m_q.push_back(s_data);
                    if (m_q.size() == 8) begin
                        for (int i = 0; i < 8; i++) m_word[8*i +: 8] = m_q[i];
                        m_wr = 1; m_q.delete();
                    end
                end
            end
        end else if (start) begin
            m_act = 1; m_done = 0; m_err = 0; m_code = 0; m_ww = 0; m_q.delete();
        end
    endfunction

    task automatic compare();
        chk("s_ready", s_ready, m_act && !m_wr);
        chk("mem_we", mem_we, m_wr);
        chk("busy", busy, m_act);
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("error_code", error_code, m_code);
        chk("words_written", words_written, 16'(m_ww));
        chk("mem_addr", mem_addr, 32'(8 * m_ww));
        if (m_wr) chk("mem_wdata", mem_wdata, m_word);
    endtask

    task automatic tick();
        compare();
        if (mem_we) wlog.push_back('{mem_addr, mem_wdata, cyc});
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic send_bytes(input logic [63:0] w, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            bit took = 0;
            if (gap) begin s_valid = 0; tick(); end
            s_valid = 1; s_data = w[8*k +: 8];
            do begin
                took = m_act && !m_wr && !abort && !reset;
                tick(); guard++;
            end while (!took && guard < 20);
            if (!took) begin
                n_chk++;
                $display("FAIL send_byte: byte %0d never accepted", k);
            end
        end
    endtask

    function automatic logic [63:0] mk_word(input int id, input bit eop);
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        w[55:48] = 8'(id);
        w[2] = eop;
        return w;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] w[5];
        logic [31:0] a_before;

        vecs[0] = '{64'h0000_1122_3344_5504, 8, 1, 1, 0, 2'd0};
        vecs[1] = '{64'h0003_0000_0000_0000, 7, 0, 0, 1, 2'd1};
        vecs[2] = '{64'h0000_0000_0000_0000, 8, 1, 0, 0, 2'd0};
        vecs[3] = '{64'h0000_0000_0000_0004, 4, 0, 0, 0, 2'd0};
        vecs[4] = '{64'hFF00_FFFF_FFFF_FFFF, 8, 1, 1, 0, 2'd0};

        @(posedge clk); model_step(); #1;
        tick();
        reset = 0;
        tick();

        // Test 1: three-word program with s_valid held high.
        wlog.delete();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            w[i] = mk_word(i, i == 2);
            send_bytes(w[i], 8, 0);
        end
        s_valid = 0;
        tick(); tick();
        chk("t1_nwrites", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            chk("t1_addr", wlog[i].a, 32'(8 * i));
            chk("t1_data", wlog[i].d, w[i]);
            if (i > 0) chk("t1_spacing", wlog[i].c - wlog[i-1].c, 9);
        end
        chk("t1_done", done, 1);
        chk("t1_ww", words_written, 3);
        chk("t1_error", error, 0);

        // Test 2: ID sequence error on the second word.
        wlog.delete();
        pulse_start();
        send_bytes(mk_word(0, 0), 8, 0);
        send_bytes(mk_word(5, 0), 7, 0);
        s_valid = 0;
        tick();
        chk("t2_code", error_code, 1);
        chk("t2_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("t2_addr", wlog[0].a, 0);
        chk("t2_ww", words_written, 1);

        // Test 3: overflow after MAXW words without an end bit.
        wlog.delete();
        pulse_start();
        for (int i = 0; i < MAXW; i++) send_bytes(mk_word(i, 0), 8, 0);
        s_data = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_nwrites", wlog.size(), MAXW);
        if (wlog.size() == MAXW) chk("t3_last_addr", wlog[MAXW-1].a, 32'h18);
        chk("t3_code", error_code, 2);
        chk("t3_ready", s_ready, 0);
        s_valid = 0;

        // Test 4: abort mid-word, then restart with a one-word program.
        wlog.delete();
        pulse_start();
        send_bytes(mk_word(0, 0), 3, 0);
        s_valid = 0; abort = 1; tick(); abort = 0;
        tick();
        chk("t4_code", error_code, 3);
        chk("t4_nwrites", wlog.size(), 0);
        pulse_start();
        chk("t4_err_clear", error, 0);
        chk("t4_ww_clear", words_written, 0);
        w[0] = mk_word(0, 1);
        send_bytes(w[0], 8, 0);
        s_valid = 0;
        tick();
        chk("t4_nwrites2", wlog.size(), 1);
        if (wlog.size() > 0) chk("t4_data", wlog[0].d, w[0]);
        chk("t4_done", done, 1);

        // Test 5: gapped stream, abort landing in the write cycle.
        wlog.delete();
        pulse_start();
        w[0] = mk_word(0, 0); w[1] = mk_word(1, 0);
        send_bytes(w[0], 8, 1);
        send_bytes(w[1], 8, 1);
        s_valid = 0;
        chk("t5_in_write", mem_we, 1);
        abort = 1; tick(); abort = 0;
        tick();
        chk("t5_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t5_addr1", wlog[1].a, 32'h8);
            chk("t5_data1", wlog[1].d, w[1]);
        end
        chk("t5_code", error_code, 3);
        chk("t5_ww", words_written, 2);

        // Test 6: reset mid-collect, then a start pulse while busy.
        pulse_start();
        send_bytes(mk_word(0, 0), 3, 0);
        s_valid = 0; reset = 1; tick(); reset = 0;
        chk("t6_busy", busy, 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_addr", mem_addr, 0);
        pulse_start();
        send_bytes(mk_word(0, 0), 8, 0);
        send_bytes(mk_word(1, 0), 2, 0);
        s_valid = 0;
        a_before = mem_addr;
        pulse_start();
        chk("t6_start_busy_addr", mem_addr, a_before);
        chk("t6_still_busy", busy, 1);
        abort = 1; tick(); abort = 0;

        // Table-driven single-session vectors.
        foreach (vecs[i]) begin
            pulse_start();
            send_bytes(vecs[i].w, vecs[i].nb, 0);
            s_valid = 0;
            chk("vec_we", mem_we, vecs[i].exp_we);
            tick();
            chk("vec_done", done, vecs[i].exp_done);
            chk("vec_error", error, vecs[i].exp_err);
            chk("vec_code", error_code, vecs[i].exp_code);
            abort = 1; tick(); abort = 0;
        end

        // Randomised traffic against the session model.
        for (int n = 0; n < 3000; n++) begin
            int qs;
            qs = m_q.size();
            reset   = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 19) == 0);
            abort   = ($urandom_range(0, 79) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            if (qs == 6 && $urandom_range(0, 7) != 0) s_data = 8'(m_ww);
            else if (qs == 0) s_data = 8'($urandom()) & (($urandom_range(0, 5) == 0) ? 8'hFF : 8'hFB);
            else s_data = 8'($urandom());
            tick();
        end
        reset = 0; start = 0; abort = 0; s_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
